// File: rtl/seq_playback_ctrl.sv
// Playback sequencer for the play_FPGA phase of the memory game.
// Optional step output for the HEX display: define SEQ_PLAY_STEP_OUT_EN.
module seq_playback_ctrl #(
    parameter int unsigned U_CYCLES = 12_500_000,
    parameter int unsigned CW       = 32
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] level,
    input  logic [1:0] seq_sel,
    input  logic [3:0] round,
    output logic [5:0] rom_addr,
    input  logic [3:0] rom_data,
    output logic [3:0] leds,
    output logic       busy,
    output logic       end_fpga
`ifdef SEQ_PLAY_STEP_OUT_EN
    ,
    output logic [3:0] step
`endif
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        SHOW  = 3'd3,
        GAP   = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [CW-1:0] ONE = CW'(1);

    state_t        state_q;
    logic          enable_q;
    logic [1:0]    level_q;
    logic [1:0]    seq_q;
    logic [3:0]    round_q;
    logic [3:0]    idx_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    leds_q;
    logic [5:0]    addr_q;

    logic          start;
    logic [CW-1:0] period;

    assign start  = enable & ~enable_q;
    assign period = CW'(U_CYCLES) << (2'd3 - level_q);

    // Playback FSM: fetch a line, show it for one period, blank for one period.
    // The address is loaded on the edge entering FETCH so the registered ROM
    // has its data ready by the time WAIT samples it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            enable_q <= 1'b0;
            level_q  <= 2'd0;
            seq_q    <= 2'd0;
            round_q  <= 4'd0;
            idx_q    <= 4'd0;
            cnt_q    <= '0;
            leds_q   <= 4'd0;
            addr_q   <= 6'd0;
        end else begin
            enable_q <= enable;
            if (state_q != IDLE && !enable) begin
                state_q <= IDLE;
                leds_q  <= 4'd0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (start) begin
                            level_q <= level;
                            seq_q   <= seq_sel;
                            round_q <= round;
                            idx_q   <= 4'd0;
                            addr_q  <= {seq_sel, 4'd0};
                            state_q <= FETCH;
                        end
                    end
                    FETCH: begin
                        addr_q  <= {seq_q, idx_q};
                        state_q <= WAIT;
                    end
                    WAIT: begin
                        leds_q  <= rom_data;
                        cnt_q   <= period - ONE;
                        state_q <= SHOW;
                    end
                    SHOW: begin
                        if (cnt_q == '0) begin
                            leds_q  <= 4'd0;
                            cnt_q   <= period - ONE;
                            state_q <= GAP;
                        end else begin
                            cnt_q <= cnt_q - ONE;
                        end
                    end
                    GAP: begin
                        if (cnt_q == '0) begin
                            if (idx_q == round_q) begin
                                state_q <= DONE;
                            end else begin
                                idx_q   <= idx_q + 4'd1;
                                addr_q  <= {seq_q, idx_q + 4'd1};
                                state_q <= FETCH;
                            end
                        end else begin
                            cnt_q <= cnt_q - ONE;
                        end
                    end
                    DONE: begin
                        leds_q <= 4'd0;
                    end
                    default: begin
                        state_q <= IDLE;
                        leds_q  <= 4'd0;
                    end
                endcase
            end
        end
    end

    // Status decoded straight from the registered state.
    always_comb begin
        busy     = (state_q == FETCH) || (state_q == WAIT) ||
                   (state_q == SHOW)  || (state_q == GAP);
        end_fpga = (state_q == DONE);
    end

    assign rom_addr = addr_q;
    assign leds     = leds_q;

`ifdef SEQ_PLAY_STEP_OUT_EN
    assign step = busy ? idx_q : 4'd0;
`endif

endmodule

// File: tb/tb_seq_playback_ctrl.sv
// Directed bench for seq_playback_ctrl with U_CYCLES=2.
// Step output checks are active when SEQ_PLAY_STEP_OUT_EN is defined.
module tb_seq_playback_ctrl;

    logic       clock;
    logic       reset;
    logic       enable;
    logic [1:0] level;
    logic [1:0] seq_sel;
    logic [3:0] round;
    logic [5:0] rom_addr;
    logic [3:0] rom_data;
    logic [3:0] leds;
    logic       busy;
    logic       end_fpga;
`ifdef SEQ_PLAY_STEP_OUT_EN
    logic [3:0] step;
`endif

    logic [3:0] rom [64];
    int tests_run;
    int tests_failed;

    seq_playback_ctrl #(.U_CYCLES(2), .CW(32)) dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .level    (level),
        .seq_sel  (seq_sel),
        .round    (round),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .leds     (leds),
        .busy     (busy),
        .end_fpga (end_fpga)
`ifdef SEQ_PLAY_STEP_OUT_EN
        ,
        .step     (step)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Registered sequence ROM model.
    always_ff @(posedge clock) rom_data <= rom[rom_addr];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        enable = 1'b0;
        tick();
        tick();
        tests_run++;
        if (leds !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_leds got %0h want 0", leds);
        end
        tests_run++;
        if (rom_addr !== 6'd0) begin
            tests_failed++;
            $display("FAIL reset_addr got %0d want 0", rom_addr);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_busy got %b want 0", busy);
        end
        tests_run++;
        if (end_fpga !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_end got %b want 0", end_fpga);
        end
`ifdef SEQ_PLAY_STEP_OUT_EN
        tests_run++;
        if (step !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_step got %0d want 0", step);
        end
`endif
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        level   = 2'd3;
        round   = 4'd0;
        seq_sel = 2'd0;
        enable  = 1'b1;
        for (int e = 0; e <= 7; e++) begin
            logic [3:0] exp_leds;
            tick();
            exp_leds = (e == 2 || e == 3) ? 4'hA : 4'h0;
            if (e == 1) begin
                tests_run++;
                if (rom_addr !== 6'd0) begin
                    tests_failed++;
                    $display("FAIL single_addr got %0d want 0", rom_addr);
                end
            end
            tests_run++;
            if (leds !== exp_leds) begin
                tests_failed++;
                $display("FAIL single_leds e=%0d got %0h want %0h",
                         e, leds, exp_leds);
            end
            tests_run++;
            if (end_fpga !== (e >= 6)) begin
                tests_failed++;
                $display("FAIL single_end e=%0d got %b want %b",
                         e, end_fpga, (e >= 6));
            end
        end
        enable = 1'b0;
        tick();
        tests_run++;
        if (end_fpga !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_end_drop got %b want 0", end_fpga);
        end
    endtask

    task automatic test_multi();
        level   = 2'd3;
        round   = 4'd2;
        seq_sel = 2'd2;
        enable  = 1'b1;
        for (int e = 0; e <= 21; e++) begin
            logic [3:0] exp_leds;
            int         ln;
            tick();
            ln = e / 6;
            exp_leds = 4'h0;
            if (e < 18 && (e % 6 == 2 || e % 6 == 3))
                exp_leds = rom[32 + ln];
            if (e < 18 && e % 6 == 1) begin
                tests_run++;
                if (rom_addr !== 6'(32 + ln)) begin
                    tests_failed++;
                    $display("FAIL multi_addr e=%0d got %0d want %0d",
                             e, rom_addr, 32 + ln);
                end
            end
            if (e >= 19) begin
                tests_run++;
                if (rom_addr !== 6'd34) begin
                    tests_failed++;
                    $display("FAIL multi_addr_hold got %0d want 34",
                             rom_addr);
                end
            end
            tests_run++;
            if (leds !== exp_leds) begin
                tests_failed++;
                $display("FAIL multi_leds e=%0d got %0h want %0h",
                         e, leds, exp_leds);
            end
            tests_run++;
            if (end_fpga !== (e >= 18)) begin
                tests_failed++;
                $display("FAIL multi_end e=%0d got %b want %b",
                         e, end_fpga, (e >= 18));
            end
            tests_run++;
            if (busy !== (e < 18)) begin
                tests_failed++;
                $display("FAIL multi_busy e=%0d got %b want %b",
                         e, busy, (e < 18));
            end
`ifdef SEQ_PLAY_STEP_OUT_EN
            tests_run++;
            if (step !== ((e < 18) ? 4'(ln) : 4'd0)) begin
                tests_failed++;
                $display("FAIL multi_step e=%0d got %0d want %0d",
                         e, step, (e < 18) ? ln : 0);
            end
`endif
        end
        enable = 1'b0;
        tick();
    endtask

    task automatic test_slow();
        level   = 2'd0;
        round   = 4'd0;
        seq_sel = 2'd1;
        enable  = 1'b1;
        for (int e = 0; e <= 36; e++) begin
            logic [3:0] exp_leds;
            tick();
            if (e == 3) begin
                level   = 2'd3;
                seq_sel = 2'd0;
                round   = 4'd5;
            end
            exp_leds = (e >= 2 && e <= 17) ? rom[16] : 4'h0;
            tests_run++;
            if (leds !== exp_leds) begin
                tests_failed++;
                $display("FAIL slow_leds e=%0d got %0h want %0h",
                         e, leds, exp_leds);
            end
            tests_run++;
            if (end_fpga !== (e >= 34)) begin
                tests_failed++;
                $display("FAIL slow_end e=%0d got %b want %b",
                         e, end_fpga, (e >= 34));
            end
        end
        enable = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        level   = 2'd3;
        round   = 4'd2;
        seq_sel = 2'd1;
        enable  = 1'b1;
        for (int e = 0; e <= 8; e++) tick();
        tests_run++;
        if (leds !== rom[17]) begin
            tests_failed++;
            $display("FAIL abort_show got %0h want %0h", leds, rom[17]);
        end
        enable = 1'b0;
        tick();
        tests_run++;
        if (leds !== 4'd0) begin
            tests_failed++;
            $display("FAIL abort_leds got %0h want 0", leds);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_busy got %b want 0", busy);
        end
        tests_run++;
        if (end_fpga !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_end got %b want 0", end_fpga);
        end
        enable = 1'b1;
        tick();
        tick();
        tests_run++;
        if (rom_addr !== 6'd16) begin
            tests_failed++;
            $display("FAIL abort_restart_addr got %0d want 16", rom_addr);
        end
        enable = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        level   = 2'd3;
        round   = 4'd1;
        seq_sel = 2'd3;
        enable  = 1'b1;
        for (int e = 0; e <= 4; e++) tick();
        tests_run++;
        if (busy !== 1'b1 || leds !== 4'd0) begin
            tests_failed++;
            $display("FAIL rmid_gap got busy=%b leds=%0h want busy=1 leds=0",
                     busy, leds);
        end
        reset = 1'b1;
        tick();
        tests_run++;
        if (leds !== 4'd0 || busy !== 1'b0 ||
            end_fpga !== 1'b0 || rom_addr !== 6'd0) begin
            tests_failed++;
            $display("FAIL rmid_reset got leds=%0h busy=%b end=%b addr=%0d want all 0",
                     leds, busy, end_fpga, rom_addr);
        end
        reset = 1'b0;
        tick();
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL rmid_restart_busy got %b want 1", busy);
        end
        tick();
        tests_run++;
        if (rom_addr !== 6'd48) begin
            tests_failed++;
            $display("FAIL rmid_restart_addr got %0d want 48", rom_addr);
        end
        tick();
        tests_run++;
        if (leds !== rom[48]) begin
            tests_failed++;
            $display("FAIL rmid_restart_leds got %0h want %0h",
                     leds, rom[48]);
        end
        enable = 1'b0;
        tick();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset   = 1'b1;
        enable  = 1'b0;
        level   = 2'd0;
        seq_sel = 2'd0;
        round   = 4'd0;
        for (int i = 0; i < 64; i++) rom[i] = 4'(i + 3);
        rom[0]  = 4'hA;
        rom[32] = 4'h1;
        rom[33] = 4'h2;
        rom[34] = 4'h4;
        test_reset();
        test_single();
        test_multi();
        test_slow();
        test_abort();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
